layer_next_fetch_control: RTL and testbench
===========================================

Name: layer_next_fetch_control

Overview:
- Read-side sequencer for the next layer: fetches the feature map the former layer left in the shared dual-port feature RAM.
- Drives the next layer's rden/address pair through the inter-layer mux and reads two words per cycle (port a even, port b odd).
- Absorbs fixed RAM read latency through a credit-controlled output FIFO and presents a valid/ready word-pair stream to the next-layer datapath.
- Raises done once every pair has been accepted.

Parameters:
- ADDR_WIDTH, 9, feature RAM address width.
- DATA_WIDTH, 16, width of one feature word.
- NUM_WORDS, 392, words per feature map; must be even and ≥2.
- RAM_LATENCY, 2, cycles from rden high to valid q; range 1..4.
- FIFO_DEPTH, 4, output FIFO depth in word pairs; power of 2, ≥ RAM_LATENCY+2.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level from the inter-layer controller. Rising edge starts a fetch; low aborts.
- base_address  in  ADDR_WIDTH  first word address; sampled at start.
- rden_a  out  1  port a read enable.
- rden_b  out  1  port b read enable.
- wren_a  out  1  tied 0.
- wren_b  out  1  tied 0.
- address_a  out  ADDR_WIDTH  port a address (even word).
- address_b  out  ADDR_WIDTH  port b address (odd word).
- q_a  in  DATA_WIDTH  port a read data.
- q_b  in  DATA_WIDTH  port b read data.
- feature_a  out  DATA_WIDTH  FIFO head, even word.
- feature_b  out  DATA_WIDTH  FIFO head, odd word.
- feature_valid  out  1  FIFO non-empty.
- feature_ready  in  1  consumer accepts the head pair when valid&ready.
- done  out  1  level; all pairs accepted, held until enable low.

Behaviour:
- Reset values: state IDLE; rden_a/b=0; address_a/b=0; feature_valid=0; feature_a/b=0; done=0. FIFO, credit counter, latency pipe and enable_delay all cleared.
- States: IDLE, FETCH, DRAIN, DONE. Any other encoding goes to IDLE.
- IDLE: when enable=1 and enable_delay=0, latch base_address, set rd_ptr=0, pairs_left=NUM_WORDS/2, and go to FETCH.
- FETCH: issue a read in a cycle only when inflight+fifo_count < FIFO_DEPTH.
  - On issue: rden_a=rden_b=1, address_a=base+rd_ptr, address_b=base+rd_ptr+1, then rd_ptr += 2.
  - Otherwise rden=0 and addresses hold their last value.
  - After issuing rd_ptr=NUM_WORDS-2, go to DRAIN.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No overflow flag.
- Latency pipe: a RAM_LATENCY-deep valid shift register tracks outstanding reads.
  - Its output pushes {q_a,q_b} into the FIFO in that cycle.
  - The pushed pair is visible on feature_* the next cycle, so first feature_valid = first rden + RAM_LATENCY + 1 cycles.
- The credit rule guarantees push never hits a full FIFO. Simultaneous push and pop in the same cycle leave fifo_count unchanged.
- Each pop (valid&ready) decrements pairs_left.
- DRAIN: when pairs_left reaches 0, go to DONE. done=1 from the next cycle.
- DONE: done=1, rden=0. When enable=0, go to IDLE; done=0 the following cycle.
- Abort: enable=0 in FETCH or DRAIN goes to IDLE next cycle.
  - FIFO and latency pipe are flushed; late q data is not pushed.
  - feature_valid=0 the cycle after enable falls; done stays 0.
- enable high continuously after DONE does not restart. A new rising edge is required.
- Asynchronous reset mid-fetch: outputs go to reset values immediately.
- feature_ready while feature_valid=0 is ignored.

Test Plan:
- Full-rate read: base=0, NUM_WORDS=8, ready=1, enable rises at cycle 0. Expect rden in cycles 1-4 with address_a=0,2,4,6 and address_b=1,3,5,7; feature_valid cycles 4-7 carrying pairs in order; done=1 from cycle 9.
- Backpressure: NUM_WORDS=16, ready held 0 after the first pair. Expect rden to stop once inflight+fifo_count reaches 4, no pair lost or duplicated, and all 8 pairs delivered in order after ready returns.
- Wrap: ADDR_WIDTH=4, base=14, NUM_WORDS=4. Expect address pairs (14,15) then (0,1).
- Abort: enable falls while 2 reads are in flight and the FIFO holds 1 pair. Expect feature_valid=0 next cycle and no later push. A new enable rising edge restarts from rd_ptr=0 with the correct first pair.
- Done handshake: hold enable high 5 cycles after done. Expect done stays 1 with no rden; enable low then done=0 within 2 cycles; re-raise enable and a second full fetch succeeds.
- Async reset asserted mid-FETCH between clock edges: rden, feature_valid and done go to 0 immediately, and state is IDLE after release.

Source files
------------

// File: rtl/layer_next_fetch_control_if.sv
// Feature RAM read port pair plus the word-pair stream handed to the next layer.
interface layer_next_fetch_control_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
);
  logic                  rden_a;
  logic                  rden_b;
  logic                  wren_a;
  logic                  wren_b;
  logic [ADDR_WIDTH-1:0] address_a;
  logic [ADDR_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] q_a;
  logic [DATA_WIDTH-1:0] q_b;
  logic [DATA_WIDTH-1:0] feature_a;
  logic [DATA_WIDTH-1:0] feature_b;
  logic                  feature_valid;
  logic                  feature_ready;

  modport master (
    output rden_a, rden_b, wren_a, wren_b, address_a, address_b,
    output feature_a, feature_b, feature_valid,
    input  q_a, q_b, feature_ready
  );

  modport slave (
    input  rden_a, rden_b, wren_a, wren_b, address_a, address_b,
    input  feature_a, feature_b, feature_valid,
    output q_a, q_b, feature_ready
  );
endinterface

// File: rtl/layer_next_fetch_control.sv
// Next-layer read sequencer: fetches word pairs from the feature RAM and streams
// them out through a credit-controlled FIFO that absorbs the RAM read latency.
module layer_next_fetch_control #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WORDS   = 392,
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_address,
  output logic                  done,
  layer_next_fetch_control_if.master bus
);
  localparam int PAIRS  = NUM_WORDS / 2;
  localparam int PTR_W  = $clog2(NUM_WORDS);
  localparam int PAIR_W = $clog2(PAIRS + 1);
  localparam int IDX_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    enable_q;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PAIR_W-1:0]       pairs_left_q, pairs_left_d;
  logic [RAM_LATENCY-1:0]  pipe_q, pipe_d;
  logic [2*DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]        count_q, count_d, inflight;
  logic                    issue, push, pop, flush, credit;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RAM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
  end

  // Reads still in the latency pipe already own a FIFO slot, so a push can never overflow.
  assign credit = ({1'b0, inflight} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign flush  = (state_q == FETCH || state_q == DRAIN) && !enable;
  assign issue  = (state_q == FETCH) && enable && credit;
  assign push   = pipe_q[RAM_LATENCY-1] && !flush;
  assign pop    = bus.feature_valid && bus.feature_ready;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    rd_ptr_d     = rd_ptr_q;
    pairs_left_d = pairs_left_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    pipe_d       = RAM_LATENCY'({pipe_q, issue});
    wr_idx_d     = wr_idx_q + IDX_W'(push);
    rd_idx_d     = rd_idx_q + IDX_W'(pop);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop) pairs_left_d = pairs_left_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (enable && !enable_q) begin
          base_d       = base_address;
          rd_ptr_d     = '0;
          pairs_left_d = PAIR_W'(PAIRS);
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (issue) begin
          addr_a_d = base_q + ADDR_WIDTH'(rd_ptr_q);
          addr_b_d = addr_a_d + 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(2);
          if (rd_ptr_q == PTR_W'(NUM_WORDS - 2)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!enable) state_d = IDLE;
        else if (pairs_left_q == '0) state_d = DONE;
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      pipe_d   = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      base_q       <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      rd_ptr_q     <= '0;
      pairs_left_q <= '0;
      pipe_q       <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      count_q      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable;
      base_q       <= base_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      rd_ptr_q     <= rd_ptr_d;
      pairs_left_q <= pairs_left_d;
      pipe_q       <= pipe_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      count_q      <= count_d;
      if (push) fifo_q[wr_idx_q] <= {bus.q_a, bus.q_b};
    end
  end

  // Addresses come straight from next-state so the issuing cycle shows the new pair.
  assign bus.rden_a        = issue;
  assign bus.rden_b        = issue;
  assign bus.wren_a        = 1'b0;
  assign bus.wren_b        = 1'b0;
  assign bus.address_a     = addr_a_d;
  assign bus.address_b     = addr_b_d;
  assign bus.feature_valid = (count_q != '0);
  assign bus.feature_a     = fifo_q[rd_idx_q][2*DATA_WIDTH-1:DATA_WIDTH];
  assign bus.feature_b     = fifo_q[rd_idx_q][DATA_WIDTH-1:0];
  assign done              = (state_q == DONE);
endmodule

// File: tb/tb_layer_next_fetch_control.sv
// Directed bench for layer_next_fetch_control with a latency-2 RAM model and
// an address/pair scoreboard filled at fetch start and drained by a monitor.
module tb_layer_next_fetch_control;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NW = 16;
  localparam int LAT = 2;
  localparam int FD = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] base_address;
  logic          done;

  layer_next_fetch_control_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  layer_next_fetch_control #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .RAM_LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .base_address(base_address),
    .done(done), .bus(bus.master)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {~a[6:0], a};
  endfunction

  // Two-stage read pipe: address in cycle t gives data during cycle t+2.
  logic [DW-1:0] sa, sb;
  always @(posedge clock) begin
    sa <= ram_word(bus.address_a);
    sb <= ram_word(bus.address_b);
    bus.q_a <= sa;
    bus.q_b <= sb;
  end

  int checks = 0, passes = 0, fails = 0;
  int issue_cnt = 0, pop_cnt = 0;
  logic [AW-1:0]   exp_addr_q[$];
  logic [2*DW-1:0] exp_pair_q[$];
  logic [AW-1:0]   mon_a, mon_b;
  logic [2*DW-1:0] mon_pair;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    for (int k = 0; k < NW / 2; k++) begin
      a = b + AW'(2 * k);
      exp_addr_q.push_back(a);
      exp_pair_q.push_back({ram_word(a), ram_word(a + 1'b1)});
    end
    base_address = b;
    enable = 1'b1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.rden_a) begin
        issue_cnt++;
        chk("rden_b", 64'(bus.rden_b), 64'(1));
        chk("wren", 64'({bus.wren_a, bus.wren_b}), 64'(0));
        chk("issue_expected", 64'(exp_addr_q.size() != 0), 64'(1));
        if (exp_addr_q.size() != 0) begin
          mon_a = exp_addr_q.pop_front();
          mon_b = mon_a + 1'b1;
          chk("address_a", 64'(bus.address_a), 64'(mon_a));
          chk("address_b", 64'(bus.address_b), 64'(mon_b));
        end
      end
      if (bus.feature_valid && bus.feature_ready) begin
        pop_cnt++;
        chk("pop_expected", 64'(exp_pair_q.size() != 0), 64'(1));
        if (exp_pair_q.size() != 0) begin
          mon_pair = exp_pair_q.pop_front();
          chk("pair", 64'({bus.feature_a, bus.feature_b}), 64'(mon_pair));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    base_address = '0;
    bus.feature_ready = 1'b0;
    #1;
    chk("rst_rden", 64'({bus.rden_a, bus.rden_b}), 64'(0));
    chk("rst_addr", 64'({bus.address_a, bus.address_b}), 64'(0));
    chk("rst_valid_done", 64'({bus.feature_valid, done}), 64'(0));
    chk("rst_feature", 64'({bus.feature_a, bus.feature_b}), 64'(0));
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Full-rate fetch from base 0, then done held with enable high.
    bus.feature_ready = 1'b1;
    issue_cnt = 0; pop_cnt = 0;
    start(9'd0);
    for (int c = 0; c <= 18; c++) begin
      @(negedge clock);
      chk("t1_rden", 64'(bus.rden_a), 64'(c >= 1 && c <= 8));
      chk("t1_valid", 64'(bus.feature_valid), 64'(c >= 4 && c <= 11));
      chk("t1_done", 64'(done), 64'(c >= 13));
    end
    @(posedge clock); #1;
    chk("t1_pops", 64'(pop_cnt), 64'(8));
    chk("t1_sb_empty", 64'(exp_pair_q.size() + exp_addr_q.size()), 64'(0));
    enable = 1'b0;
    @(negedge clock);
    chk("t1_done_hold", 64'(done), 64'(1));
    @(negedge clock);
    chk("t1_done_clear", 64'(done), 64'(0));

    // Second fetch crossing the top of the address space.
    @(posedge clock); #1;
    issue_cnt = 0; pop_cnt = 0;
    start(9'd510);
    for (int c = 0; c <= 14; c++) begin
      @(negedge clock);
      chk("t2_rden", 64'(bus.rden_a), 64'(c >= 1 && c <= 8));
      chk("t2_valid", 64'(bus.feature_valid), 64'(c >= 4 && c <= 11));
      chk("t2_done", 64'(done), 64'(c >= 13));
    end
    @(posedge clock); #1;
    chk("t2_pops", 64'(pop_cnt), 64'(8));
    enable = 1'b0;
    repeat (2) @(posedge clock); #1;

    // Backpressure: consumer stalls after the first pair.
    issue_cnt = 0; pop_cnt = 0;
    start(9'd100);
    repeat (5) @(negedge clock);
    @(posedge clock); #1 bus.feature_ready = 1'b0;
    repeat (10) @(negedge clock);
    chk("t3_stall_rden", 64'(bus.rden_a), 64'(0));
    chk("t3_stall_valid", 64'(bus.feature_valid), 64'(1));
    @(posedge clock); #1;
    chk("t3_stall_issues", 64'(issue_cnt), 64'(5));
    chk("t3_stall_pops", 64'(pop_cnt), 64'(1));
    bus.feature_ready = 1'b1;
    for (int i = 0; i < 400 && done !== 1'b1; i++) @(negedge clock);
    chk("t3_done", 64'(done), 64'(1));
    @(posedge clock); #1;
    chk("t3_issues", 64'(issue_cnt), 64'(8));
    chk("t3_pops", 64'(pop_cnt), 64'(8));
    chk("t3_sb_empty", 64'(exp_pair_q.size()), 64'(0));
    enable = 1'b0;
    repeat (2) @(posedge clock); #1;

    // Abort with two reads in flight and one pair queued.
    issue_cnt = 0; pop_cnt = 0;
    bus.feature_ready = 1'b0;
    start(9'd0);
    repeat (4) @(negedge clock);
    @(posedge clock); #1 enable = 1'b0;
    @(negedge clock);
    chk("t4_valid_before", 64'(bus.feature_valid), 64'(1));
    chk("t4_rden_abort", 64'(bus.rden_a), 64'(0));
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk("t4_valid_flushed", 64'(bus.feature_valid), 64'(0));
      chk("t4_done", 64'(done), 64'(0));
    end
    @(posedge clock); #1;
    chk("t4_issues", 64'(issue_cnt), 64'(3));
    exp_addr_q.delete();
    exp_pair_q.delete();
    issue_cnt = 0; pop_cnt = 0;
    bus.feature_ready = 1'b1;
    start(9'd0);
    for (int i = 0; i < 400 && done !== 1'b1; i++) @(negedge clock);
    chk("t4_restart_done", 64'(done), 64'(1));
    @(posedge clock); #1;
    chk("t4_restart_pops", 64'(pop_cnt), 64'(8));
    chk("t4_sb_empty", 64'(exp_pair_q.size()), 64'(0));
    enable = 1'b0;
    repeat (2) @(posedge clock); #1;

    // Asynchronous reset between edges in the middle of a fetch.
    issue_cnt = 0; pop_cnt = 0;
    start(9'd0);
    repeat (6) @(negedge clock);
    chk("t5_pre", 64'({bus.rden_a, bus.feature_valid}), 64'(2'b11));
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_rden", 64'({bus.rden_a, bus.rden_b}), 64'(0));
    chk("t5_rst_valid", 64'(bus.feature_valid), 64'(0));
    chk("t5_rst_done", 64'(done), 64'(0));
    chk("t5_rst_addr", 64'(bus.address_a), 64'(0));
    @(posedge clock); #1 enable = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    exp_addr_q.delete();
    exp_pair_q.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("t5_idle", 64'({bus.rden_a, bus.feature_valid, done}), 64'(0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
